pc_sequencer: RTL

Fetch sequencer for the single-cycle core: owns the program counter register, drives the instruction-memory read handshake, and decides each cycle whether the PC advances and to which address. It sits between the datapath (branch/jump/halt decode, data-memory stall) and the instruction-memory port of the memory controller. It replaces ad-hoc Adv/next_PC wiring with one arbitrated update point.

---
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 70 +++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: instruction-memory handshake plus datapath redirect/stall inputs.
// PC_SEQ_PERF_EN adds the retired/stall performance counters to the bundle.
interface pc_sequencer_if;
  logic        ihit;
  logic        dstall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        halt_in;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        adv;
  logic        halted;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  modport master (
    input  ihit, dstall, br_taken, br_target, jmp, jmp_target, halt_in,
    output iren, iaddr, pc, npc, adv, halted, retired_cnt, stall_cnt
  );
  modport slave (
    output ihit, dstall, br_taken, br_target, jmp, jmp_target, halt_in,
    input  iren, iaddr, pc, npc, adv, halted, retired_cnt, stall_cnt
  );
`else
  modport master (
    input  ihit, dstall, br_taken, br_target, jmp, jmp_target, halt_in,
    output iren, iaddr, pc, npc, adv, halted
  );
  modport slave (
    output ihit, dstall, br_taken, br_target, jmp, jmp_target, halt_in,
    input  iren, iaddr, pc, npc, adv, halted
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner and instruction-fetch sequencer (BOOT -> FETCH -> HALTED).
// Optional PC_SEQ_PERF_EN adds retired_cnt / stall_cnt counters.
module pc_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          n_rst,
  pc_sequencer_if.master bus
);
  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc_q, pc_nxt, npc;
  logic        fetch, sample;

  assign npc    = pc_q + 32'd4;
  assign fetch  = (state == FETCH);
  // redirect/halt inputs only carry meaning when the instruction can retire
  assign sample = fetch & bus.ihit & ~bus.dstall;

  assign bus.iren   = fetch;
  assign bus.iaddr  = pc_q;
  assign bus.pc     = pc_q;
  assign bus.npc    = npc;
  assign bus.adv    = sample & ~bus.halt_in;
  assign bus.halted = (state == HALTED);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    case (state)
      BOOT:   state_nxt = FETCH;
      FETCH: begin
        if (sample) begin
          if (bus.halt_in)       state_nxt = HALTED;
          else if (bus.jmp)      pc_nxt    = bus.jmp_target & ~32'd3;
          else if (bus.br_taken) pc_nxt    = bus.br_target & ~32'd3;
          else                   pc_nxt    = npc;
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= BOOT;
      pc_q  <= PC_INIT;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

`ifdef PC_SEQ_PERF_EN
  // HALT sampling counts as a retired instruction even though adv stays low
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.retired_cnt <= 32'd0;
      bus.stall_cnt   <= 32'd0;
    end else begin
      if (sample)                            bus.retired_cnt <= bus.retired_cnt + 32'd1;
      if (fetch & (~bus.ihit | bus.dstall))  bus.stall_cnt   <= bus.stall_cnt + 32'd1;
    end
  end
`endif
endmodule
